// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared constants and types for the freq_meas round-robin sequencer.
//   Register offsets and CTRL/STATUS bit positions of the freq_meas slave,
//   the sequencer FSM state type and the AXI OKAY response code.
package freq_meas_pkg;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_GATE   = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h8;
    localparam logic [3:0] REG_COUNT  = 4'hC;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CH_LSB    = 4;
    localparam int STAT_DONE_BIT  = 0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_WR_GATE,
        S_WR_CTRL,
        S_RD_STAT,
        S_RD_CNT,
        S_STORE
    } state_t;

endpackage

// File: rtl/freq_meas_axil_single.sv
// freq_meas_axil_single: performs one AXI4-Lite read or write per accepted request.
//   ACLK/ARESET : clock, async active-high reset
//   req/we      : request (level, accepted when no transfer is active) and direction
//   addr/wdata  : transfer address and write data
//   ack         : one-cycle completion strobe; resp_ok/rdata are valid with it
//   m_axi_*     : AXI4-Lite master channels
module freq_meas_axil_single
    import freq_meas_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic              resp_ok,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    logic wr_act, rd_act, b_done, b_ok;
    logic aw_fin, w_fin, b_hs, wr_ack, rd_ack;

    // A write finishes in the cycle its last outstanding handshake (AW, W or B) completes.
    assign aw_fin  = !m_axi_awvalid || m_axi_awready;
    assign w_fin   = !m_axi_wvalid || m_axi_wready;
    assign b_hs    = m_axi_bready && m_axi_bvalid;
    assign wr_ack  = wr_act && aw_fin && w_fin && (b_done || b_hs);
    assign rd_ack  = rd_act && m_axi_rready && m_axi_rvalid;
    assign ack     = wr_ack || rd_ack;
    assign resp_ok = wr_act ? (b_hs ? m_axi_bresp == RESP_OKAY : b_ok) : m_axi_rresp == RESP_OKAY;
    assign rdata   = m_axi_rdata;
    assign m_axi_wstrb = 4'hF;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_act        <= 1'b0;
            rd_act        <= 1'b0;
            b_done        <= 1'b0;
            b_ok          <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            if (req && !wr_act && !rd_act) begin
                if (we) begin
                    wr_act        <= 1'b1;
                    b_done        <= 1'b0;
                    b_ok          <= 1'b1;
                    m_axi_awaddr  <= addr;
                    m_axi_wdata   <= wdata;
                    m_axi_awvalid <= 1'b1;
                    m_axi_wvalid  <= 1'b1;
                    m_axi_bready  <= 1'b1;
                end else begin
                    rd_act        <= 1'b1;
                    m_axi_araddr  <= addr;
                    m_axi_arvalid <= 1'b1;
                    m_axi_rready  <= 1'b1;
                end
            end
            if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wvalid && m_axi_wready) m_axi_wvalid <= 1'b0;
            if (b_hs) begin
                m_axi_bready <= 1'b0;
                b_done       <= 1'b1;
                b_ok         <= m_axi_bresp == RESP_OKAY;
            end
            if (wr_ack) wr_act <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;
            if (rd_ack) begin
                m_axi_rready <= 1'b0;
                rd_act       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/freq_meas_sched.sv
// freq_meas_sched: round-robin AXI4-Lite sequencer sharing one freq_meas counter across NUM_CH channels.
//   ACLK/ARESET  : clock, async active-high reset
//   run          : keep sequencing while high; the channel in progress finishes when it drops
//   ch_en        : per-channel enable, looked at when the next channel is chosen
//   gate_cycles  : gate length programmed for every measurement
//   m_axi_*      : AXI4-Lite master toward freq_meas S00_AXI
//   result       : last count per channel, channel k at [32k+31:32k]
//   result_valid : count captured; cleared when that channel's next measurement starts
//   err_timeout  : sticky, done never seen within POLL_MAX STATUS reads
//   err_resp     : sticky, a non-OKAY response was seen for the channel
//   busy         : FSM not idle
module freq_meas_sched
    import freq_meas_pkg::*;
#(
    parameter int                NUM_CH    = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                POLL_MAX  = 1024
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 run,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic [31:0]          gate_cycles,
    output logic [ADDR_W-1:0]    m_axi_awaddr,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [31:0]          m_axi_wdata,
    output logic [3:0]           m_axi_wstrb,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic [ADDR_W-1:0]    m_axi_araddr,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [31:0]          m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready,
    output logic [NUM_CH*32-1:0] result,
    output logic [NUM_CH-1:0]    result_valid,
    output logic [NUM_CH-1:0]    err_timeout,
    output logic [NUM_CH-1:0]    err_resp,
    output logic                 busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PC_W = $clog2(POLL_MAX + 1);

    state_t            state, state_n;
    logic [CH_W-1:0]   ptr, ch, sel_ch, idx;
    logic              sel_found;
    logic [31:0]       gate_r;
    logic [PC_W-1:0]   poll_cnt;
    logic              cnt_ok, poll_last, done;
    logic              req, we, ack, resp_ok;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata, rdata;

    assign poll_last = poll_cnt == PC_W'(POLL_MAX - 1);
    assign done      = rdata[STAT_DONE_BIT];
    assign busy      = state != S_IDLE;

    // First enabled channel at or after the pointer; scanning downward lets the nearest one win.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        idx       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(ptr) + i) % NUM_CH);
            if (ch_en[idx]) begin
                sel_found = 1'b1;
                sel_ch    = idx;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        req     = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        case (state)
            S_IDLE:    state_n = run ? S_SEL : S_IDLE;
            S_SEL:     state_n = sel_found ? S_WR_GATE : S_IDLE;
            S_WR_GATE: begin
                req     = 1'b1;
                we      = 1'b1;
                addr    = BASE_ADDR + ADDR_W'(REG_GATE);
                wdata   = gate_r;
                state_n = ack ? S_WR_CTRL : S_WR_GATE;
            end
            S_WR_CTRL: begin
                req     = 1'b1;
                we      = 1'b1;
                addr    = BASE_ADDR + ADDR_W'(REG_CTRL);
                wdata   = (32'(4'(ch)) << CTRL_CH_LSB) | (32'd1 << CTRL_START_BIT);
                state_n = ack ? S_RD_STAT : S_WR_CTRL;
            end
            S_RD_STAT: begin
                req     = 1'b1;
                addr    = BASE_ADDR + ADDR_W'(REG_STATUS);
                state_n = !ack ? S_RD_STAT : done ? S_RD_CNT : poll_last ? S_STORE : S_RD_STAT;
            end
            S_RD_CNT: begin
                req     = 1'b1;
                addr    = BASE_ADDR + ADDR_W'(REG_COUNT);
                state_n = ack ? S_STORE : S_RD_CNT;
            end
            S_STORE:   state_n = run ? S_SEL : S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ptr          <= '0;
            ch           <= '0;
            gate_r       <= '0;
            poll_cnt     <= '0;
            cnt_ok       <= 1'b0;
            result       <= '0;
            result_valid <= '0;
            err_timeout  <= '0;
            err_resp     <= '0;
        end else begin
            case (state)
                S_SEL: if (sel_found) begin
                    ch                   <= sel_ch;
                    gate_r               <= gate_cycles;
                    poll_cnt             <= '0;
                    cnt_ok               <= 1'b0;
                    result_valid[sel_ch] <= 1'b0;
                end
                S_RD_STAT: if (ack && !done) begin
                    poll_cnt <= poll_cnt + 1'b1;
                    if (poll_last) err_timeout[ch] <= 1'b1;
                end
                S_RD_CNT: if (ack) begin
                    result[int'(ch)*32 +: 32] <= rdata;
                    cnt_ok                    <= resp_ok;
                end
                S_STORE: begin
                    if (cnt_ok) result_valid[ch] <= 1'b1;
                    ptr <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
                end
                default: ;
            endcase
            if (ack && !resp_ok) err_resp[ch] <= 1'b1;
        end
    end

    freq_meas_axil_single #(.ADDR_W(ADDR_W)) u_axil (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .req           (req),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .ack           (ack),
        .resp_ok       (resp_ok),
        .rdata         (rdata),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

endmodule

// File: tb/tb_freq_meas_sched.sv
// tb_freq_meas_sched: randomized bench for freq_meas_sched with a reactive freq_meas slave and a round-robin reference model.
module tb_freq_meas_sched;

    localparam int          NCH  = 4;
    localparam int          PMAX = 8;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic           ACLK, ARESET, run;
    logic [NCH-1:0] ch_en;
    logic [31:0]    gate_cycles;
    logic [31:0]    m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic           m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]     m_axi_wstrb;
    logic [1:0]     m_axi_bresp, m_axi_rresp;
    logic           m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic           m_axi_rvalid, m_axi_rready;
    logic [NCH*32-1:0] result;
    logic [NCH-1:0] result_valid, err_timeout, err_resp;
    logic           busy;

    freq_meas_sched #(.NUM_CH(NCH), .ADDR_W(32), .BASE_ADDR(BASE), .POLL_MAX(PMAX)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .run(run), .ch_en(ch_en), .gate_cycles(gate_cycles),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .result(result),
        .result_valid(result_valid), .err_timeout(err_timeout), .err_resp(err_resp), .busy(busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int n_chk = 0, n_pass = 0;
    int mode;
    int aw_dly, w_dly, b_dly, ar_dly, r_dly;
    bit aw_got, w_got, ar_got, prev_bready, b_commit, s_done;
    logic [31:0] aw_a, w_d, ar_a, tmp;
    int cur_ch, stat_n, gate_n, bad_gate_n;
    int aw_hs, w_hs, b_hs, viol;
    int stat_tot[16];
    int done_after[16];
    logic [31:0] cnt_val[16];
    wr_t wlog[$];
    int  ctrl_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int rnd_dly();
        return (mode == 0) ? int'($urandom_range(0, 3)) : 0;
    endfunction

    // freq_meas slave: decides ready/valid at negedge, so each decision is the handshake of the next posedge.
    always @(negedge ACLK) begin
        if (ARESET) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
            m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
            aw_got = 0; w_got = 0; ar_got = 0; prev_bready = 0; b_commit = 0;
            aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        end else begin
            if (prev_bready && !m_axi_bready && !b_commit) viol++;
            prev_bready = m_axi_bready;
            if (m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid || m_axi_bready)) viol++;
            b_commit = 0;
            m_axi_bvalid = 0;
            m_axi_rvalid = 0;
            if (aw_got && w_got) begin
                if (b_dly > 0) b_dly--;
                else if (m_axi_bready) begin
                    m_axi_bvalid = 1; b_commit = 1; b_hs++;
                    m_axi_bresp = 2'b00;
                    wlog.push_back('{aw_a - BASE, w_d});
                    if (aw_a - BASE == 32'h4) begin
                        gate_n++;
                        if (gate_n == bad_gate_n) m_axi_bresp = 2'b10;
                    end
                    if (aw_a - BASE == 32'h0) begin
                        cur_ch = int'(w_d[7:4]);
                        stat_n = 0;
                        ctrl_q.push_back(cur_ch);
                    end
                    aw_got = 0; w_got = 0;
                    aw_dly = rnd_dly(); w_dly = rnd_dly(); b_dly = rnd_dly();
                end
            end
            if (ar_got) begin
                if (r_dly > 0) r_dly--;
                else if (m_axi_rready) begin
                    m_axi_rvalid = 1;
                    m_axi_rresp = 2'b00;
                    tmp = $urandom;
                    if (ar_a - BASE == 32'h8) begin
                        stat_n++;
                        stat_tot[cur_ch]++;
                        s_done = done_after[cur_ch] != 0 && stat_n >= done_after[cur_ch];
                        m_axi_rdata = {tmp[31:1], s_done};
                    end else if (ar_a - BASE == 32'hC) m_axi_rdata = cnt_val[cur_ch];
                    else m_axi_rdata = tmp;
                    ar_got = 0;
                    ar_dly = rnd_dly(); r_dly = rnd_dly();
                end
            end
            m_axi_awready = 0;
            if (m_axi_awvalid) begin
                if (aw_got || ar_got) viol++;
                else if (mode != 1 || w_got) begin
                    if (aw_dly > 0) aw_dly--;
                    else begin
                        m_axi_awready = 1; aw_got = 1; aw_a = m_axi_awaddr; aw_hs++;
                        if (mode == 2) w_dly = 3;
                    end
                end
            end
            m_axi_wready = 0;
            if (m_axi_wvalid) begin
                if (w_got || ar_got) viol++;
                else if (mode != 2 || aw_got) begin
                    if (w_dly > 0) w_dly--;
                    else begin
                        m_axi_wready = 1; w_got = 1; w_d = m_axi_wdata; w_hs++;
                        if (m_axi_wstrb != 4'hF) viol++;
                        if (mode == 1) aw_dly = 2;
                    end
                end
            end
            m_axi_arready = 0;
            if (m_axi_arvalid) begin
                if (ar_got || aw_got || w_got) viol++;
                else if (ar_dly > 0) ar_dly--;
                else begin
                    m_axi_arready = 1; ar_got = 1; ar_a = m_axi_araddr;
                end
            end
        end
    end

    task automatic clear_logs();
        wlog.delete();
        ctrl_q.delete();
        gate_n = 0; aw_hs = 0; w_hs = 0; b_hs = 0; viol = 0; cur_ch = 0; stat_n = 0;
        for (int k = 0; k < 16; k++) stat_tot[k] = 0;
    endtask

    task automatic do_reset();
        ARESET = 1;
        run = 0;
        @(negedge ACLK);
        @(negedge ACLK);
        clear_logs();
        ARESET = 0;
        @(negedge ACLK);
    endtask

    task automatic wait_ctrl(input int n);
        int t = 0;
        while (ctrl_q.size() < n && t < 4000) begin
            @(negedge ACLK);
            t++;
        end
        chk("ctrl_seen", ctrl_q.size() >= n, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 4000) begin
            @(negedge ACLK);
            t++;
        end
        chk("idle", busy, 0);
    endtask

    task automatic run_round(input int n);
        run = 1;
        wait_ctrl(n);
        run = 0;
        wait_idle();
    endtask

    // Reference: n-th measured channel when walking enabled channels cyclically from channel 0.
    function automatic int exp_ch(input logic [3:0] en, input int n);
        int c = 0;
        for (int j = 0; j <= n; j++) begin
            while (!en[c % 4]) c++;
            if (j < n) c++;
        end
        return c % 4;
    endfunction

    function automatic bit meas_ok(input int k);
        return done_after[k] >= 1 && done_after[k] <= PMAX;
    endfunction

    task automatic check_round(input logic [3:0] en, input int n);
        logic [3:0] e_valid, e_to, e_resp;
        int m;
        e_valid = 0; e_to = 0; e_resp = 0;
        chk("ctrl_count", ctrl_q.size(), n);
        chk("wr_count", wlog.size(), 2 * n);
        for (int j = 0; j < n && j < ctrl_q.size(); j++) chk("ctrl_ch", ctrl_q[j], exp_ch(en, j));
        for (int j = 0; j < n && 2 * j + 1 < wlog.size(); j++) begin
            chk("gate_addr", wlog[2*j].a, 32'h4);
            chk("gate_data", wlog[2*j].d, gate_cycles);
            chk("ctrl_addr", wlog[2*j+1].a, 32'h0);
            chk("ctrl_data", wlog[2*j+1].d, (exp_ch(en, j) << 4) | 1);
        end
        if (bad_gate_n >= 1 && bad_gate_n <= n) e_resp[exp_ch(en, bad_gate_n - 1)] = 1;
        for (int k = 0; k < 4; k++) begin
            m = 0;
            for (int j = 0; j < n; j++) if (exp_ch(en, j) == k) m++;
            e_valid[k] = m > 0 && meas_ok(k);
            e_to[k]    = m > 0 && !meas_ok(k);
            chk("stat_reads", stat_tot[k], m * (meas_ok(k) ? done_after[k] : PMAX));
            chk("result", result[k*32 +: 32], e_valid[k] ? cnt_val[k] : 32'h0);
        end
        chk("result_valid", result_valid, e_valid);
        chk("err_timeout", err_timeout, e_to);
        chk("err_resp", err_resp, e_resp);
        chk("protocol", viol, 0);
    endtask

    task automatic randomize_slave();
        for (int k = 0; k < 16; k++) begin
            done_after[k] = $urandom_range(1, 5);
            cnt_val[k]    = $urandom;
        end
        gate_cycles = $urandom;
    endtask

    initial begin
        ARESET = 1; run = 0; ch_en = 0; gate_cycles = 0; mode = 0; bad_gate_n = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        randomize_slave();
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {result_valid, err_timeout, err_resp}, 0);
        chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        chk("rst_addr", {m_axi_awaddr, m_axi_araddr, m_axi_wdata}, 0);

        // One full round, done on the third STATUS read
        for (int k = 0; k < 16; k++) begin
            done_after[k] = 3;
            cnt_val[k]    = 32'h1234 + k;
        end
        gate_cycles = 100;
        ch_en = 4'b1111;
        run_round(4);
        check_round(4'b1111, 4);

        // Sparse enable mask
        do_reset();
        randomize_slave();
        ch_en = 4'b1010;
        run_round(4);
        check_round(4'b1010, 4);

        // ch2 never reports done
        do_reset();
        randomize_slave();
        done_after[2] = 0;
        ch_en = 4'b1111;
        run_round(4);
        check_round(4'b1111, 4);

        // Skewed AW/W acceptance in both orders
        for (int md = 1; md <= 2; md++) begin
            mode = md;
            do_reset();
            randomize_slave();
            ch_en = 4'b0001;
            run_round(1);
            check_round(4'b0001, 1);
            chk("aw_hs", aw_hs, 2);
            chk("w_hs", w_hs, 2);
            chk("b_hs", b_hs, 2);
        end
        mode = 0;

        // SLVERR on ch1 GATE write
        do_reset();
        randomize_slave();
        bad_gate_n = 2;
        ch_en = 4'b1111;
        run_round(4);
        check_round(4'b1111, 4);
        bad_gate_n = 0;

        // Async reset while polling ch2
        do_reset();
        randomize_slave();
        done_after[2] = 0;
        ch_en = 4'b1111;
        run = 1;
        for (int t = 0; t < 4000 && !(ctrl_q.size() >= 3 && stat_tot[2] >= 3); t++) @(negedge ACLK);
        chk("reach_stat2", stat_tot[2] >= 3, 1);
        @(posedge ACLK);
        #3 ARESET = 1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_result", result, 0);
        chk("arst_flags", {result_valid, err_timeout, err_resp}, 0);
        chk("arst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        @(negedge ACLK);
        @(negedge ACLK);
        clear_logs();
        for (int k = 0; k < 16; k++) done_after[k] = 2;
        ARESET = 0;
        wait_ctrl(1);
        chk("arst_first_ch", ctrl_q.size() > 0 ? ctrl_q[0] : -1, 0);
        run = 0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
